// File: rtl/usb_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_bit_timer
// Purpose  : USB RX bit timing: phase recovery, per-bit shift strobe,
//            byte-complete pulse, optional bit unstuffing (USB_RX_UNSTUFF_EN).
// Revision : 1.0
// ============================================================================
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_err
);

    localparam int c_phase_w = $clog2(CLKS_PER_BIT);
    localparam int c_cnt_w   = $clog2(BITS_PER_BYTE + 1);

    localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(CLKS_PER_BIT - 1);
    localparam logic [c_phase_w-1:0] c_sample_pt  = c_phase_w'(SAMPLE_POINT);
    localparam logic [c_phase_w-1:0] c_phase_one  = c_phase_w'(1);
    localparam logic [c_cnt_w-1:0]   c_bit_last   = c_cnt_w'(BITS_PER_BYTE - 1);
    localparam logic [c_cnt_w-1:0]   c_bit_one    = c_cnt_w'(1);

    logic [c_phase_w-1:0] r_phase;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic                 r_byte_received;

    logic w_sample;
    logic w_stuffed;
    logic w_shift;
    logic w_byte_done;

    // Reset gating keeps the strobe low while reset is held, whatever SAMPLE_POINT is.
    assign w_sample     = rcving && (r_phase == c_sample_pt);
    assign w_shift      = n_rst && w_sample && !w_stuffed;
    assign w_byte_done  = w_shift && (r_bit_cnt == c_bit_last);

    assign shift_enable  = w_shift;
    assign byte_received = r_byte_received;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase         <= '0;
            r_bit_cnt       <= '0;
            r_byte_received <= 1'b0;
        end else begin
            // Completion pulse survives a simultaneous rcving drop.
            r_byte_received <= w_byte_done;
            if (!rcving) begin
                r_phase   <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (d_edge || (r_phase == c_phase_last)) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + c_phase_one;
                end

                if (w_byte_done) begin
                    r_bit_cnt <= '0;
                end else if (w_shift) begin
                    r_bit_cnt <= r_bit_cnt + c_bit_one;
                end
            end
        end
    end

`ifdef USB_RX_UNSTUFF_EN
    logic [2:0] r_ones_cnt;
    logic       r_stuff_err;

    // Six consecutive ones force the next sampled bit to be a stuffed zero.
    assign w_stuffed = w_sample && (r_ones_cnt == 3'd6);
    assign stuff_err = r_stuff_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ones_cnt  <= 3'd0;
            r_stuff_err <= 1'b0;
        end else begin
            r_stuff_err <= w_stuffed && d_orig;
            if (!rcving || w_stuffed) begin
                r_ones_cnt <= 3'd0;
            end else if (w_sample) begin
                r_ones_cnt <= d_orig ? (r_ones_cnt + 3'd1) : 3'd0;
            end
        end
    end
`else
    logic w_unused_d_orig;

    assign w_unused_d_orig = d_orig;
    assign w_stuffed       = 1'b0;
    assign stuff_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_bit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_bit_timer
// Purpose  : Directed and randomized checks of usb_rx_bit_timer against a
//            cycle-count reference model.
// Revision : 1.0
// ============================================================================
module tb_usb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int BPB = 8;
`ifdef USB_RX_UNSTUFF_EN
    localparam bit UNSTUFF = 1'b1;
`else
    localparam bit UNSTUFF = 1'b0;
`endif

    logic clk    = 1'b0;
    logic n_rst  = 1'b0;
    logic rcving = 1'b0;
    logic d_edge = 1'b0;
    logic d_orig = 1'b0;
    logic shift_enable;
    logic byte_received;
    logic stuff_err;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT  (CPB),
        .SAMPLE_POINT  (SP),
        .BITS_PER_BYTE (BPB)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rcving        (rcving),
        .d_edge        (d_edge),
        .d_orig        (d_orig),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .stuff_err     (stuff_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phase is cycles elapsed since the last anchor
    // (first receiving cycle or the cycle after an edge), modulo CPB.
    int m_anchor    = 0;
    int m_bits      = 0;
    int m_run       = 0;
    bit m_pend_byte = 1'b0;
    bit m_pend_err  = 1'b0;

    bit obs_shift, obs_byte, obs_err;

    int first_sh, n_sh, n_by, n_er, by1, by2, er1, sh_after;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycle(input bit rcv, input bit de, input bit dd);
        int ph;
        bit smp, stf, exp_sh;
        rcving = rcv;
        d_edge = de;
        d_orig = dd;
        ph     = (cyc - m_anchor) % CPB;
        smp    = rcv && (ph == SP);
        stf    = UNSTUFF && smp && (m_run >= 6);
        exp_sh = smp && !stf;
        @(negedge clk);
        obs_shift = shift_enable;
        obs_byte  = byte_received;
        obs_err   = stuff_err;
        check("shift_enable", shift_enable, exp_sh);
        check("byte_received", byte_received, m_pend_byte);
        check("stuff_err", stuff_err, m_pend_err);
        @(posedge clk);
        cyc++;
        m_pend_byte = exp_sh && (((m_bits + 1) % BPB) == 0);
        m_pend_err  = stf && dd;
        if (exp_sh) m_bits++;
        if (stf) m_run = 0;
        else if (smp) m_run = dd ? m_run + 1 : 0;
        if (!rcv) begin
            m_bits   = 0;
            m_run    = 0;
            m_anchor = cyc;
        end else if (de) begin
            m_anchor = cyc;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        first_sh = -1; n_sh = 0; n_by = 0; n_er = 0;
        by1 = -1; by2 = -1; er1 = -1; sh_after = -1;
    endtask

    task automatic tally(input int rel);
        if (obs_shift) begin
            n_sh++;
            if (first_sh < 0) first_sh = rel;
        end
        if (obs_byte) begin
            n_by++;
            if (by1 < 0) by1 = rel;
            else if (by2 < 0) by2 = rel;
        end
        if (obs_err) begin
            n_er++;
            if (er1 < 0) er1 = rel;
        end
    endtask

    initial begin
        #1;
        check("rst_shift", shift_enable, 1'b0);
        check("rst_byte", byte_received, 1'b0);
        check("rst_err", stuff_err, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 n_rst = 1'b1;
        cyc = 0; m_anchor = 0;
        idle(3);

        // Clean line, no edges: bytes complete at 60 and 124.
        clear_stats();
        for (int i = 0; i < 130; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            tally(i);
        end
        check("first_shift_cycle", first_sh, 3);
        check("shift_count_130", n_sh, 16);
        check("byte_count_130", n_by, 2);
        check("byte1_cycle", by1, 60);
        check("byte2_cycle", by2, 124);
        idle(2);

        // Resync at cycle 14 moves the next sample to 18.
        clear_stats();
        for (int i = 0; i < 30; i++) begin
            run_cycle(1'b1, (i == 14), 1'b0);
            if (i > 14 && obs_shift && sh_after < 0) sh_after = i;
        end
        check("resync_next_shift", sh_after, 18);
        idle(2);

        // Drop after 5 shifts discards the partial byte.
        clear_stats();
        for (int i = 0; i < 37; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            tally(i);
        end
        idle(3);
        check("partial_shifts", n_sh, 5);
        check("partial_no_byte", n_by, 0);
        clear_stats();
        for (int i = 0; i < 64; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            tally(i);
        end
        check("rearm_byte_cycle", by1, 60);
        idle(2);

        // Six ones then a zero on the 7th sample.
        clear_stats();
        for (int i = 0; i < 56; i++) begin
            run_cycle(1'b1, 1'b0, (i < 48));
            tally(i);
        end
        check("six_ones_shifts", n_sh, UNSTUFF ? 6 : 7);
        check("six_ones_err", n_er, 0);
        idle(2);

        // Seven ones: violation when unstuffing.
        clear_stats();
        for (int i = 0; i < 56; i++) begin
            run_cycle(1'b1, 1'b0, 1'b1);
            tally(i);
        end
        check("seven_ones_shifts", n_sh, UNSTUFF ? 6 : 7);
        check("seven_ones_err", n_er, UNSTUFF ? 1 : 0);
        check("seven_ones_err_cycle", er1, UNSTUFF ? 52 : -1);
        idle(2);

        // Asynchronous reset during a sample cycle mid-packet.
        for (int i = 0; i < 19; i++) run_cycle(1'b1, 1'b0, 1'b0);
        rcving = 1'b1; d_edge = 1'b0; d_orig = 1'b0;
        #2;
        check("pre_reset_shift", shift_enable, 1'b1);
        n_rst = 1'b0;
        #1;
        check("async_rst_shift", shift_enable, 1'b0);
        check("async_rst_byte", byte_received, 1'b0);
        check("async_rst_err", stuff_err, 1'b0);
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1 n_rst = 1'b1;
        m_anchor = cyc; m_bits = 0; m_run = 0; m_pend_byte = 0; m_pend_err = 0;
        clear_stats();
        for (int i = 0; i < 66; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0);
            tally(i);
        end
        check("post_rst_first_shift", first_sh, 3);
        check("post_rst_byte_cycle", by1, 60);

        // Randomized traffic: edges, drops and ones-heavy data.
        begin
            bit rcv = 1'b1;
            int off = 0;
            for (int i = 0; i < 4000; i++) begin
                if (off > 0) begin
                    off--;
                    rcv = (off == 0);
                end else if ($urandom_range(0, 299) == 0) begin
                    off = $urandom_range(1, 5);
                    rcv = 1'b0;
                end
                run_cycle(rcv, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 85));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
